// File: rtl/ad1939_pkg.sv
// Shared defaults, FSM state encoding and channel numbering for the AD1939 DAC-side deserializer.
package ad1939_pkg;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_SLOT_WIDTH = 32;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Line k left -> 2k, line k right -> 2k+1 (side: 0 = left, 1 = right).
   function automatic int ch(input int line, input logic side);
      return 2 * line + (side ? 1 : 0);
   endfunction

endpackage

// File: rtl/ad1939_line_shifter.sv
// One dsdata line: MSB-first shift register loaded only while the bit-window enable is high.
// Latency 1 clk per bit; no backpressure, the word is consumed by the parent at the slot boundary.
module ad1939_line_shifter #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  shift_en,
   input  logic                  sdata,
   output logic [DATA_WIDTH-1:0] word
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word <= '0;
      end else if (shift_en) begin
         word <= {word[DATA_WIDTH-2:0], sdata};
      end
   end

endmodule

// File: rtl/ad1939_dac_deserializer.sv
// Recovers parallel samples from the oversampled AD1939 DAC I2S stream onto an Avalon-ST source.
// First word valid 4 clk after the boundary dbclk pin edge; a slot completing while words are pending is dropped.
module ad1939_dac_deserializer
   import ad1939_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
   parameter int N_LINES    = 2,
   parameter int CH_WIDTH   = $clog2(2 * N_LINES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  dac_dbclk,
   input  logic                  dac_dlrclk,
   input  logic [N_LINES-1:0]    dac_dsdata,
   output logic [DATA_WIDTH-1:0] avalon_st_data,
   output logic [CH_WIDTH-1:0]   avalon_st_channel,
   output logic                  avalon_st_valid,
   input  logic                  avalon_st_ready,
   output logic                  locked,
   output logic                  overflow,
   output logic                  frame_error
);

   localparam int CNT_W  = $clog2(SLOT_WIDTH + 1);
   localparam int IDX_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1;
   localparam int LEFT_W = $clog2(N_LINES + 1);

   logic               bclk_s1, bclk_s2, bclk_d;
   logic               lr_s1, lr_s2, lr_q;
   logic [N_LINES-1:0] dat_s1, dat_s2, dat_q;
   logic               rise;

   logic               primed;
   logic               lr_prev;
   logic [CNT_W-1:0]   bit_cnt;
   logic               boundary;
   logic               shift_en;

   state_t             state_q, state_d;
   logic               slot_ok, slot_bad;

   logic [DATA_WIDTH-1:0] line_word [N_LINES];
   logic [DATA_WIDTH-1:0] pend_word [N_LINES];
   logic                  pend_side;
   logic [IDX_W-1:0]      rd_idx;
   logic [LEFT_W-1:0]     pend_left;
   logic                  accept;
   logic                  last_beat;
   logic                  can_load;

   // Data and lrclk are delayed alongside bclk so they are seen exactly as they were at the rise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_d  <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         lr_q    <= 1'b0;
         dat_s1  <= '0;
         dat_s2  <= '0;
         dat_q   <= '0;
         rise    <= 1'b0;
      end else begin
         bclk_s1 <= dac_dbclk;
         bclk_s2 <= bclk_s1;
         bclk_d  <= bclk_s2;
         lr_s1   <= dac_dlrclk;
         lr_s2   <= lr_s1;
         lr_q    <= lr_s2;
         dat_s1  <= dac_dsdata;
         dat_s2  <= dat_s1;
         dat_q   <= dat_s2;
         rise    <= bclk_s2 & ~bclk_d;
      end
   end

   // The first rise after reset only learns the lrclk level, so a reset never fakes a boundary.
   assign boundary = rise && primed && (lr_q != lr_prev);
   assign shift_en = rise && !boundary && (bit_cnt < CNT_W'(DATA_WIDTH));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         primed  <= 1'b0;
         lr_prev <= 1'b0;
         bit_cnt <= '0;
      end else if (rise) begin
         primed  <= 1'b1;
         lr_prev <= lr_q;
         if (boundary) begin
            bit_cnt <= '0;
         end else if (bit_cnt != CNT_W'(SLOT_WIDTH)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < N_LINES; k++) begin : g_line
      ad1939_line_shifter #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_shift (
         .clk     (clk),
         .reset_n (reset_n),
         .shift_en(shift_en),
         .sdata   (dat_q[k]),
         .word    (line_word[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // bit_cnt still holds the last bit index of the ending slot when its boundary rise arrives.
   always_comb begin
      state_d  = state_q;
      slot_ok  = 1'b0;
      slot_bad = 1'b0;
      case (state_q)
         SYNC: begin
            if (boundary) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (boundary) begin
               if (bit_cnt == CNT_W'(SLOT_WIDTH - 1)) begin
                  slot_ok = 1'b1;
               end else begin
                  slot_bad = 1'b1;
                  state_d  = SYNC;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   assign avalon_st_valid   = (pend_left != '0);
   assign avalon_st_data    = pend_word[rd_idx];
   assign avalon_st_channel = CH_WIDTH'(ch(int'(rd_idx), pend_side));

   assign accept    = avalon_st_valid && avalon_st_ready;
   assign last_beat = accept && (pend_left == LEFT_W'(1));
   assign can_load  = (pend_left == '0) || last_beat;

   // Draining the last word on the boundary cycle frees the buffer in time for the new slot.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < N_LINES; k++) begin
            pend_word[k] <= '0;
         end
         pend_side   <= 1'b0;
         rd_idx      <= '0;
         pend_left   <= '0;
         locked      <= 1'b0;
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (slot_ok && can_load) begin
            for (int k = 0; k < N_LINES; k++) begin
               pend_word[k] <= line_word[k];
            end
            pend_side <= lr_prev;
            rd_idx    <= '0;
            pend_left <= LEFT_W'(N_LINES);
         end else if (accept) begin
            rd_idx    <= last_beat ? '0 : rd_idx + 1'b1;
            pend_left <= pend_left - 1'b1;
         end

         if (slot_ok) begin
            locked <= 1'b1;
         end
         if (slot_ok && !can_load) begin
            overflow <= 1'b1;
         end
         if (slot_bad) begin
            frame_error <= 1'b1;
         end
      end
   end

endmodule
